// File: rtl/spi_reg_controller_if.sv
// Host-side request/response bundle for the SPI register controller.
// master = host issuing requests, slave = the controller serving them.
interface spi_reg_controller_if #(
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  start;
   logic                  rw;
   logic [ADDR_WIDTH-1:0] addr;
   logic [REG_WIDTH-1:0]  wdata;
   logic [1:0]            spi_mode;
   logic                  ready;
   logic                  done;
   logic [REG_WIDTH-1:0]  rdata;

   modport master (
      output start, rw, addr, wdata, spi_mode,
      input  ready, done, rdata
   );

   modport slave (
      input  start, rw, addr, wdata, spi_mode,
      output ready, done, rdata
   );
endinterface

// File: rtl/spi_reg_controller.sv
// SPI master: one cs-framed {cmd,data} transfer per request; done at 1+(2N+1)*CLK_DIV+CS_GAP cycles
// after accept. No queueing: start is ignored while busy; ena low freezes everything.
module spi_reg_controller #(
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int CLK_DIV    = 4,
   parameter int CS_GAP     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   spi_reg_controller_if.slave  req,
   output logic                 spi_cs_n,
   output logic                 spi_clk,
   output logic                 spi_mosi,
   input  logic                 spi_miso
);
   localparam int N       = 8 + REG_WIDTH;
   localparam int EDGES   = 2 * N;
   localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int EDGE_W  = $clog2(EDGES + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [EDGE_W-1:0]    edge_cnt_q, edge_cnt_d;
   logic [N-1:0]         sh_q, sh_d;
   logic [REG_WIDTH-1:0] rx_q, rx_d;
   logic [REG_WIDTH-1:0] rdata_q, rdata_d;
   logic                 cpha_q, cpha_d;
   logic                 cs_n_q, cs_n_d;
   logic                 sclk_q, sclk_d;
   logic                 mosi_q, mosi_d;
   logic                 ready_q, ready_d;
   logic                 done_q, done_d;

   logic [7:0]           cmd;
   logic [N-1:0]         frame;
   logic [REG_WIDTH:0]   rx_ext;
   logic                 odd_edge, last_edge, sample_now, update_now, div_wrap;

   always_comb begin
      cmd        = 8'(req.addr);
      cmd[7]     = req.rw;
      frame      = {cmd, req.rw ? req.wdata : {REG_WIDTH{1'b0}}};
      rx_ext     = {rx_q, spi_miso};
      // edge_cnt_q counts edges already issued, so the upcoming edge is odd when it is even
      odd_edge   = ~edge_cnt_q[0];
      last_edge  = (edge_cnt_q == EDGE_W'(EDGES - 1));
      sample_now = cpha_q ? ~odd_edge : odd_edge;
      update_now = cpha_q ? odd_edge : (~odd_edge & ~last_edge);
      div_wrap   = (cnt_q == CNT_W'(CLK_DIV - 1));

      state_d    = state_q;
      cnt_d      = cnt_q;
      edge_cnt_d = edge_cnt_q;
      sh_d       = sh_q;
      rx_d       = rx_q;
      rdata_d    = rdata_q;
      cpha_d     = cpha_q;
      cs_n_d     = cs_n_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      ready_d    = ready_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            sclk_d = req.spi_mode[1];
            mosi_d = 1'b0;
            if (req.start) begin
               state_d    = SETUP;
               ready_d    = 1'b0;
               cs_n_d     = 1'b0;
               cnt_d      = '0;
               edge_cnt_d = '0;
               cpha_d     = req.spi_mode[0];
               if (req.spi_mode[0]) begin
                  sh_d = frame;
               end else begin
                  mosi_d = frame[N-1];
                  sh_d   = frame << 1;
               end
            end
         end
         SETUP, SHIFT: begin
            if (div_wrap) begin
               cnt_d      = '0;
               sclk_d     = ~sclk_q;
               edge_cnt_d = edge_cnt_q + EDGE_W'(1);
               state_d    = last_edge ? HOLD : SHIFT;
               if (sample_now) begin
                  rx_d = rx_ext[REG_WIDTH-1:0];
               end
               if (update_now) begin
                  mosi_d = sh_q[N-1];
                  sh_d   = sh_q << 1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (div_wrap) begin
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == CNT_W'(CS_GAP - 1)) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               rdata_d = rx_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         edge_cnt_q <= '0;
         sh_q       <= '0;
         rx_q       <= '0;
         rdata_q    <= '0;
         cpha_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else if (ena) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         edge_cnt_q <= edge_cnt_d;
         sh_q       <= sh_d;
         rx_q       <= rx_d;
         rdata_q    <= rdata_d;
         cpha_q     <= cpha_d;
         cs_n_q     <= cs_n_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign req.ready = ready_q;
   assign req.done  = done_q;
   assign req.rdata = rdata_q;
   assign spi_cs_n  = cs_n_q;
   assign spi_clk   = sclk_q;
   assign spi_mosi  = mosi_q;
endmodule

// File: tb/tb_spi_reg_controller.sv
// Bench for spi_reg_controller: behavioural SPI peripheral plus per-request expectations
// derived from the frame format and the documented cycle budget.
module tb_spi_reg_controller;
   localparam int RW      = 8;
   localparam int AW      = 3;
   localparam int CD      = 4;
   localparam int GAPC    = 2;
   localparam int NB      = 8 + RW;
   localparam int LAT     = 1 + (2 * NB + 1) * CD + GAPC;
   localparam int FREEZE  = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ena = 1'b1;
   logic spi_cs_n, spi_clk, spi_mosi;
   logic spi_miso = 1'b0;

   int checks = 0;
   int errors = 0;

   spi_reg_controller_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) ifc ();

   spi_reg_controller #(
      .REG_WIDTH(RW), .ADDR_WIDTH(AW), .CLK_DIV(CD), .CS_GAP(GAPC)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .req(ifc.slave),
      .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Peripheral model: answers a frame with slv_word (command byte slot is junk, data slot is the
   // register value) and records what it saw on MOSI, counting edges and cs-low cycles.
   logic [1:0]  slv_mode = 2'b00;
   logic [15:0] slv_word = 16'h0000;
   logic [15:0] slv_cap  = 16'h0000;
   int          slv_edges = 0, slv_cs_low = 0, slv_bad = 0;
   logic        prev_cs = 1'b1, prev_clk = 1'b0, prev_mosi = 1'b0;

   always @(negedge clk) begin
      int idx;
      if (spi_cs_n === 1'b0) begin
         if (prev_cs !== 1'b0) begin
            slv_edges  = 0;
            slv_cap    = 16'h0000;
            slv_cs_low = 0;
            slv_bad    = 0;
            if (!slv_mode[0]) spi_miso = slv_word[15];
         end else begin
            if (spi_clk !== prev_clk) begin
               slv_edges++;
               if (slv_edges[0] != slv_mode[0]) begin
                  slv_cap = {slv_cap[14:0], spi_mosi};
               end else begin
                  idx = slv_mode[0] ? 15 - (slv_edges - 1) / 2 : 15 - slv_edges / 2;
                  if (idx >= 0 && idx <= 15) spi_miso = slv_word[idx];
               end
            end
            if (spi_mosi !== prev_mosi &&
                (spi_clk === prev_clk || slv_edges[0] != slv_mode[0])) slv_bad++;
         end
         slv_cs_low++;
      end
      prev_cs   = spi_cs_n;
      prev_clk  = spi_clk;
      prev_mosi = spi_mosi;
   end

   task automatic scramble_inputs();
      ifc.rw       = 1'($urandom);
      ifc.addr     = 3'($urandom);
      ifc.wdata    = 8'($urandom);
      ifc.spi_mode = 2'($urandom);
   endtask

   task automatic run_txn(input logic t_rw, input logic [2:0] t_addr, input logic [7:0] t_wd,
                          input logic [1:0] t_mode, input logic [7:0] t_rv,
                          input bit t_freeze, input bit t_poke);
      int         rel, done_rel, dones, exp_done;
      bit         fin;
      logic [4:0] snap;
      logic [15:0] exp_word;
      exp_word = {t_rw, 4'b0000, t_addr, (t_rw ? t_wd : 8'h00)};
      exp_done = LAT + (t_freeze ? FREEZE : 0);
      snap     = '0;

      @(negedge clk);
      ifc.spi_mode = t_mode;
      @(negedge clk);
      check_eq("idle_sclk", 32'(spi_clk), 32'(t_mode[1]));
      check_eq("idle_ready", 32'(ifc.ready), 32'd1);
      slv_mode  = t_mode;
      slv_word  = {8'($urandom), t_rv};
      ifc.rw    = t_rw;
      ifc.addr  = t_addr;
      ifc.wdata = t_wd;
      ifc.start = 1'b1;
      @(negedge clk);
      rel = 1;
      ifc.start = 1'b0;
      scramble_inputs();
      check_eq("ready_drop", 32'(ifc.ready), 32'd0);
      check_eq("cs_low_t1", 32'(spi_cs_n), 32'd0);

      done_rel = -1;
      dones    = 0;
      fin      = 1'b0;
      while (!fin && rel < 400) begin
         if (ifc.done === 1'b1) begin
            dones++;
            if (done_rel < 0) begin
               done_rel = rel;
               check_eq("rdata", 32'(ifc.rdata), 32'(t_rv));
            end
         end
         if (t_poke) begin
            ifc.start = (rel == 10);
            if (rel == 10) scramble_inputs();
         end
         if (t_freeze) begin
            if (rel == 40) begin
               ena  = 1'b0;
               snap = {spi_cs_n, spi_clk, spi_mosi, ifc.ready, ifc.done};
            end
            if (rel == 40 + FREEZE - 1)
               check_eq("frozen", 32'({spi_cs_n, spi_clk, spi_mosi, ifc.ready, ifc.done}),
                        32'(snap));
            if (rel == 40 + FREEZE) ena = 1'b1;
         end
         if (done_rel >= 0 && rel == done_rel + 1) begin
            check_eq("ready_back", 32'(ifc.ready), 32'd1);
            fin = 1'b1;
         end else begin
            @(negedge clk);
            rel++;
         end
      end
      ifc.start = 1'b0;
      ena       = 1'b1;
      check_eq("done_cycle", 32'(done_rel), 32'(exp_done));
      check_eq("done_count", 32'(dones), 32'd1);
      check_eq("mosi_word", 32'(slv_cap), 32'(exp_word));
      check_eq("sclk_edges", 32'(slv_edges), 32'(2 * NB));
      check_eq("cs_low_len", 32'(slv_cs_low), 32'((2 * NB + 1) * CD + (t_freeze ? FREEZE : 0)));
      check_eq("mosi_timing", 32'(slv_bad), 32'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_cs"}, 32'(spi_cs_n), 32'd1);
      check_eq({tag, "_sclk"}, 32'(spi_clk), 32'd0);
      check_eq({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
      check_eq({tag, "_ready"}, 32'(ifc.ready), 32'd1);
      check_eq({tag, "_done"}, 32'(ifc.done), 32'd0);
      check_eq({tag, "_rdata"}, 32'(ifc.rdata), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen_done;
      ifc.start    = 1'b0;
      ifc.rw       = 1'b0;
      ifc.addr     = '0;
      ifc.wdata    = '0;
      ifc.spi_mode = 2'b00;
      repeat (3) @(negedge clk);
      check_reset_state("por");
      rst = 1'b0;

      run_txn(1'b1, 3'd2, 8'hA5, 2'b00, 8'h5E, 1'b0, 1'b0);
      run_txn(1'b0, 3'd1, 8'h77, 2'b00, 8'hCA, 1'b0, 1'b0);
      run_txn(1'b0, 3'd6, 8'h00, 2'b11, 8'h3C, 1'b0, 1'b0);
      run_txn(1'b1, 3'd5, 8'h96, 2'b01, 8'h81, 1'b0, 1'b1);
      run_txn(1'b0, 3'd3, 8'h00, 2'b10, 8'hE7, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++)
         run_txn(1'($urandom), 3'($urandom), 8'($urandom), 2'($urandom), 8'($urandom),
                 (i == 2), (i == 4));

      // Abort a frame mid-shift with a simultaneous start: reset must win, no done afterwards.
      @(negedge clk);
      ifc.spi_mode = 2'b00;
      slv_mode  = 2'b00;
      slv_word  = {8'h00, 8'h99};
      ifc.rw    = 1'b0;
      ifc.addr  = 3'd4;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (50) @(negedge clk);
      check_eq("pre_rst_busy", 32'(spi_cs_n), 32'd0);
      rst       = 1'b1;
      ifc.start = 1'b1;
      @(negedge clk);
      check_reset_state("abort");
      rst       = 1'b0;
      ifc.start = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ifc.done === 1'b1) seen_done++;
      end
      check_eq("abort_no_done", 32'(seen_done), 32'd0);
      check_eq("abort_idle", 32'({spi_cs_n, ifc.ready}), 32'b11);

      run_txn(1'b0, 3'd7, 8'h00, 2'b00, 8'h42, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
